// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: one read or write per request, fixed-length
// strobe sequencing, all SRAM-side signals driven from flops.
module sram_ctrl #(
   parameter int RD_WAIT  = 2,  // cycles oe_n held low before data is sampled (1-15)
   parameter int WR_PULSE = 2   // cycles we_n held low per write (1-15)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [19:0] addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy,
   inout  wire  [31:0] ram_data,
   output logic [19:0] ram_addr,
   output logic [3:0]  ram_be_n,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n
);

   typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [19:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        ack_q, ack_d;
   logic        ce_n_q, ce_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;
   logic [3:0]  be_n_q, be_n_d;
   logic        drv_q, drv_d;
   logic        accept;
   logic [3:0]  be_eff;

   // Requests are only looked at while idle; everything after that uses latched copies.
   assign accept = (state_q == IDLE) && req;
   // WSETUP is entered on the acceptance edge, before be_q holds the new value.
   assign be_eff = accept ? be : be_q;

   // Next-state and wait-counter sequencing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (we) begin
                  state_d = WSETUP;
               end else begin
                  state_d = RD;
                  cnt_d   = 4'(RD_WAIT - 1);
               end
            end
         end
         RD: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         WSETUP: begin
            state_d = WPULSE;
            cnt_d   = 4'(WR_PULSE - 1);
         end
         WPULSE: begin
            if (cnt_q == 4'd0) state_d = WHOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         WHOLD:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // SRAM strobes decoded from the upcoming state so the flops line up with it.
   always_comb begin
      ce_n_d = 1'b1;
      oe_n_d = 1'b1;
      we_n_d = 1'b1;
      be_n_d = 4'hF;
      drv_d  = 1'b0;
      ack_d  = 1'b0;
      case (state_d)
         RD: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
            be_n_d = 4'h0;
         end
         WSETUP, WHOLD: begin
            ce_n_d = 1'b0;
            be_n_d = ~be_eff;
            drv_d  = 1'b1;
         end
         WPULSE: begin
            ce_n_d = 1'b0;
            we_n_d = 1'b0;
            be_n_d = ~be_eff;
            drv_d  = 1'b1;
         end
         DONE:    ack_d = 1'b1;
         default: ;
      endcase
   end

   // FSM state, counter and registered SRAM-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         be_n_q  <= 4'hF;
         drv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         be_n_q  <= be_n_d;
         drv_q   <= drv_d;
      end
   end

   // Request capture and read-data sampling on the final RD cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= 20'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         if (accept) begin
            addr_q  <= addr;
            be_q    <= be;
            wdata_q <= wdata;
         end
         if (state_q == RD && cnt_q == 4'd0) rdata_q <= ram_data;
      end
   end

   assign ram_data = drv_q ? wdata_q : 32'hz;
   assign ram_addr = addr_q;
   assign ram_be_n = be_n_q;
   assign ram_ce_n = ce_n_q;
   assign ram_oe_n = oe_n_q;
   assign ram_we_n = we_n_q;
   assign rdata    = rdata_q;
   assign ack      = ack_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (default and RD_WAIT=4/WR_PULSE=3),
// each on its own SRAM array model, checked against a word-level scoreboard.
module tb_sram_ctrl;

   logic clk = 1'b0;
   logic rst, fill;
   logic [1:0]       req, we, ack, busy, ce_n, oe_n, we_n;
   logic [1:0][19:0] addr, raddr;
   logic [1:0][3:0]  be, be_n;
   logic [1:0][31:0] wdata, rdata;
   wire  [31:0]      bus0, bus1;
   logic [31:0]      mem     [2][256];
   logic [31:0]      ref_mem [2][256];
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_ctrl #(.RD_WAIT(2), .WR_PULSE(2)) dut0 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .be(be[0]),
      .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .ram_data(bus0),
      .ram_addr(raddr[0]), .ram_be_n(be_n[0]), .ram_ce_n(ce_n[0]), .ram_oe_n(oe_n[0]),
      .ram_we_n(we_n[0]));

   sram_ctrl #(.RD_WAIT(4), .WR_PULSE(3)) dut1 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .be(be[1]),
      .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .ram_data(bus1),
      .ram_addr(raddr[1]), .ram_be_n(be_n[1]), .ram_ce_n(ce_n[1]), .ram_oe_n(oe_n[1]),
      .ram_we_n(we_n[1]));

   // SRAM drives on oe; with the chip deselected a keeper pulls the bus to 0,
   // so any leftover controller drive shows up as a non-zero value.
   assign bus0 = ce_n[0] ? 32'h0 : (!oe_n[0] ? mem[0][raddr[0][7:0]] : 32'hz);
   assign bus1 = ce_n[1] ? 32'h0 : (!oe_n[1] ? mem[1][raddr[1][7:0]] : 32'hz);

   function automatic int rdw(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   function automatic int wrp(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic logic [31:0] seed_word(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] en);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] bus_of(input int d);
      return (d == 0) ? bus0 : bus1;
   endfunction

   // SRAM array: bytes with be_n low take the bus on each clock with ce_n and we_n low.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (fill) begin
            for (int i = 0; i < 256; i++) mem[d][i] <= seed_word(i + d * 256);
         end else if (!ce_n[d] && !we_n[d]) begin
            mem[d][raddr[d][7:0]] <= merge(mem[d][raddr[d][7:0]], bus_of(d), ~be_n[d]);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on instance d. Called #1 after an edge; returns #1 after the ack edge.
   task automatic txn(input int d, input bit w, input logic [19:0] a, input logic [3:0] b,
                      input logic [31:0] wd, input bit hold, input string tag,
                      output logic [31:0] rd, output int idle_n, output int ack_at);
      int k, we_lo, oe_lo, bad;
      bit started, done, setup_ok, hold_ok, addr_ok, ben_ok, fin_ok;
      logic [31:0] exp_rd;
      k = 0; we_lo = 0; oe_lo = 0; bad = 0; idle_n = 0; ack_at = 0; rd = 32'h0;
      started = 0; done = 0; setup_ok = 0; hold_ok = !w; addr_ok = 0; ben_ok = 0; fin_ok = 0;
      exp_rd = ref_mem[d][a[7:0]];
      req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
      for (int n = 0; n < 60 && !done; n++) begin
         @(posedge clk); #1;
         if (!started) begin
            if (busy[d]) begin started = 1; k = 1; end
            else idle_n++;
         end else k++;
         if (started) begin
            if (k == 1) begin
               addr_ok  = (raddr[d] == a);
               ben_ok   = w ? (be_n[d] == ~b) : (be_n[d] == 4'h0);
               setup_ok = w ? (!ce_n[d] && we_n[d]) : (!ce_n[d] && !oe_n[d]);
               if (!hold) begin
                  addr[d] = 20'($urandom); be[d] = 4'($urandom);
                  wdata[d] = $urandom; we[d] = ~w;
               end
            end
            if (w && k == wrp(d) + 2) hold_ok = !ce_n[d] && we_n[d];
            if (!we_n[d]) we_lo++;
            if (!oe_n[d]) begin
               oe_lo++;
               if (bus_of(d) !== mem[d][a[7:0]] || !we_n[d]) bad++;
            end
            if (w && !ce_n[d] && bus_of(d) !== wd) bad++;
            if (ack[d]) begin
               done   = 1;
               ack_at = cyc;
               rd     = rdata[d];
               fin_ok = ce_n[d] && oe_n[d] && we_n[d] && be_n[d] == 4'hF && bus_of(d) === 32'h0;
               if (!hold) req[d] = 1'b0;
            end
         end
      end
      check({tag, " ack seen"}, 32'(done), 32'd1);
      check({tag, " latency"}, 32'(k), 32'(w ? wrp(d) + 3 : rdw(d) + 1));
      check({tag, " strobe width"}, 32'(w ? we_lo : oe_lo), 32'(w ? wrp(d) : rdw(d)));
      check({tag, " other strobe"}, 32'(w ? oe_lo : we_lo), 32'd0);
      check({tag, " bus integrity"}, 32'(bad), 32'd0);
      check({tag, " addr"}, 32'(addr_ok), 32'd1);
      check({tag, " be_n"}, 32'(ben_ok), 32'd1);
      check({tag, " setup/hold"}, 32'(setup_ok && hold_ok), 32'd1);
      check({tag, " done idle bus"}, 32'(fin_ok), 32'd1);
      if (w) ref_mem[d][a[7:0]] = merge(ref_mem[d][a[7:0]], wd, b);
      else   check({tag, " rdata"}, rd, exp_rd);
   endtask

   logic [31:0] rd, rd2;
   int idle_n, t1, t2, acks;

   initial begin
      rst = 1'b1; fill = 1'b1;
      req = '0; we = '0; addr = '0; be = '0; wdata = '0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) ref_mem[d][i] = seed_word(i + d * 256);
      repeat (2) @(posedge clk);
      #1;
      fill = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check("reset strobes", {25'd0, ce_n[d], oe_n[d], we_n[d], be_n[d]}, 32'h7F);
         check("reset ram_addr", {12'd0, raddr[d]}, 32'd0);
         check("reset rdata", rdata[d], 32'd0);
         check("reset ack/busy", {30'd0, ack[d], busy[d]}, 32'd0);
         check("reset bus released", bus_of(d), 32'h0);
      end
      rst = 1'b0;

      // Full-word write then read back.
      txn(0, 1, 20'h00010, 4'hF, 32'h12345678, 0, "wr full", rd, idle_n, t1);
      txn(0, 0, 20'h00010, 4'h0, 32'h0, 0, "rd full", rd, idle_n, t1);
      check("rd full value", rd, 32'h12345678);

      // Single byte lane 1.
      txn(0, 1, 20'h00010, 4'b0010, 32'hAABBCCDD, 0, "wr byte1", rd, idle_n, t1);
      txn(0, 0, 20'h00010, 4'h0, 32'h0, 0, "rd byte1", rd, idle_n, t1);
      check("rd byte1 value", rd, 32'h1234CC78);

      // No byte enables: full sequence, memory untouched.
      txn(0, 1, 20'h00010, 4'h0, 32'hFFFFFFFF, 0, "wr be0", rd, idle_n, t1);
      txn(0, 0, 20'h00010, 4'h0, 32'h0, 0, "rd be0", rd, idle_n, t1);
      check("rd be0 value", rd, 32'h1234CC78);

      // Request held across two back-to-back reads.
      txn(0, 0, 20'h00000, 4'h0, 32'h0, 1, "rd hold a", rd, idle_n, t1);
      txn(0, 0, 20'h00001, 4'h0, 32'h0, 0, "rd hold b", rd2, idle_n, t2);
      check("held req idle cycles", 32'(idle_n), 32'd1);
      check("held req ack spacing", 32'(t2 - t1), 32'd4);

      // Reset during the write pulse aborts cleanly.
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 20'h00080; be[0] = 4'hF; wdata[0] = 32'hCAFEF00D;
      t1 = 0;
      for (int n = 0; n < 20 && t1 == 0; n++) begin
         @(posedge clk); #1;
         if (!we_n[0]) t1 = 1;
      end
      check("abort reached WPULSE", 32'(t1), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort strobes", {29'd0, ce_n[0], oe_n[0], we_n[0]}, 32'h7);
      check("abort busy", 32'(busy[0]), 32'd0);
      check("abort bus released", bus0, 32'h0);
      rst = 1'b0; req[0] = 1'b0;
      acks = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ack[0]) acks++;
      end
      check("abort no ack", 32'(acks), 32'd0);
      ref_mem[0][8'h80] = mem[0][8'h80];  // partial write leaves this word undefined

      // Reset wins over a simultaneous request.
      req[0] = 1'b1; we[0] = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      check("rst over req", 32'(busy[0]), 32'd0);
      rst = 1'b0; req[0] = 1'b0;
      @(posedge clk); #1;

      // Longer timing instance.
      txn(1, 1, 20'h00020, 4'hF, 32'hDEADBEEF, 0, "slow wr", rd, idle_n, t1);
      txn(1, 0, 20'h00020, 4'h0, 32'h0, 0, "slow rd", rd, idle_n, t1);
      check("slow rd value", rd, 32'hDEADBEEF);

      // Random traffic on both instances.
      for (int i = 0; i < 40; i++) begin
         int d;
         bit w;
         d = int'($urandom_range(0, 1));
         w = 1'($urandom);
         txn(d, w, 20'($urandom_range(0, 63)), 4'($urandom), $urandom, 0,
             $sformatf("rnd%0d", i), rd, idle_n, t1);
      end
      for (int a = 0; a < 64; a += 7)
         txn(a % 2, 0, 20'(a), 4'h0, 32'h0, 0, $sformatf("sweep%0d", a), rd, idle_n, t1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter RD_WAIT, default 2: cycles oe_n held low before read data is sampled (legal range 1-15).
REQ-002 SHALL have parameter WR_PULSE, default 2: cycles we_n held low per write (legal range 1-15).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 req  in  1  request valid; held by the requester until ack.
REQ-007 we  in  1  1 = write, 0 = read.
REQ-008 addr  in  20  word address.
REQ-009 be  in  4  active-high byte enables; be[0] selects data[7:0].
REQ-010 wdata  in  32  write data.
REQ-011 rdata  out  32  read data; valid from ack until the next read completes.
REQ-012 ack  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high while a transaction is in progress (any non-IDLE state).
REQ-014 ram_data  inout  32  SRAM data bus.
REQ-015 ram_addr  out  20  SRAM address.
REQ-016 ram_be_n, ram_ce_n, ram_oe_n, ram_we_n  out  4/1/1/1  SRAM byte enables and strobes, active-low.

Function
REQ-017 The FSM SHALL have states IDLE, RD, WSETUP, WPULSE, WHOLD, DONE, with an internal 4-bit wait counter.
REQ-018 In IDLE with req=1, addr/be/wdata/we SHALL be latched; the next state SHALL be RD if we=0, else WSETUP; input changes after latching SHALL be ignored.
REQ-019 RD SHALL drive ce_n=0, oe_n=0, be_n=4'h0, we_n=1, latched address, ram_data high-Z, for RD_WAIT cycles.
REQ-020 On the last RD cycle, ram_data SHALL be registered into rdata and the next state SHALL be DONE.
REQ-021 WSETUP SHALL last 1 cycle: ce_n=0, we_n=1, oe_n=1, be_n=~be, ram_data driven with latched wdata.
REQ-022 WPULSE SHALL last WR_PULSE cycles, identical to WSETUP except we_n=0.
REQ-023 WHOLD SHALL last 1 cycle, identical to WSETUP (we_n=1, data still driven); the next state SHALL be DONE.
REQ-024 DONE SHALL last 1 cycle: ack=1, ce_n=oe_n=we_n=1, be_n=4'hF, ram_data high-Z; the next state SHALL be IDLE.
REQ-025 Latency, with the acceptance edge as cycle 0: read ack SHALL appear in cycle RD_WAIT+1 (3 at default); write ack in cycle WR_PULSE+3 (5 at default).
REQ-026 req SHALL be sampled only in IDLE; a request held past the DONE cycle SHALL be accepted as a new transaction in IDLE (minimum 1 idle cycle between transactions).
REQ-027 ram_data SHALL be driven only in WSETUP/WPULSE/WHOLD; oe_n=0 and a driven bus SHALL never coincide.
REQ-028 A write with be=4'h0 SHALL run the full write sequence with be_n=4'hF and ack normally.
REQ-029 All SRAM control outputs SHALL be registered (glitch-free); ram_addr SHALL hold its last value in IDLE and DONE.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, ce_n=oe_n=we_n=1, be_n=4'hF, ram_addr=0, rdata=0, ack=0, busy=0, ram_data high-Z.
REQ-031 rst asserted mid-transaction SHALL abort it: strobes deasserted and bus released in the next cycle, no ack, SRAM contents from a partial write undefined.
REQ-032 rst SHALL take priority over any req in the same cycle.

Verification
REQ-033 Write 0x12345678 to addr 0x00010, be=4'hF, then read 0x00010 -> rdata=0x12345678; write ack in cycle 5, read ack in cycle 3.
REQ-034 Byte write wdata=0xAABBCCDD, be=4'b0010 to addr 0x00010, then read -> rdata=0x1234CC78.
REQ-035 Write waveform check -> we_n low exactly 2 cycles; ram_data stable 1 cycle before and after the we_n pulse; oe_n=1 throughout; no bus contention in any read.
REQ-036 rst pulsed during WPULSE -> next cycle we_n=1, ce_n=1, ram_data=Z, busy=0; ack never asserted.
REQ-037 req held high across two reads (addr 0x00000, then 0x00001) -> two acks 4 cycles apart, each with correct data, and exactly one IDLE cycle between transactions.
REQ-038 RD_WAIT=4, WR_PULSE=3 -> read ack in cycle 5, write ack in cycle 6, we_n low exactly 3 cycles.
